// File: rtl/pipe_field_scroller_if.sv
// Game-control and pixel-query bundle between the pipe field and its neighbours.
// The master side (tick generator / pixel mux) drives the requests; the slave side is the pipe field.
interface pipe_field_scroller_if;
  logic       game_tick;
  logic       start;
  logic       halt;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       pipe_on;
  logic       pipe_lower;
  logic [13:0] rom_addr;
  logic       score_pulse;
  logic       running;

  modport master (
    output game_tick, start, halt, pixel_x, pixel_y,
    input  pipe_on, pipe_lower, rom_addr, score_pulse, running
  );

  modport slave (
    input  game_tick, start, halt, pixel_x, pixel_y,
    output pipe_on, pipe_lower, rom_addr, score_pulse, running
  );
endinterface

// File: rtl/pipe_field_scroller.sv
// Pipe field for Flappy Bird: scrolls/respawns NUM_PIPES pipe pairs and answers pixel queries.
// Define PIPE_RANDOM_GAP_EN for LFSR gap heights; otherwise a +37 respawn counter sets them.
module pipe_field_scroller #(
  parameter int NUM_PIPES      = 3,
  parameter int PIPE_W         = 41,
  parameter int IMG_H          = 253,
  parameter int GAP            = 70,
  parameter int GAP_MIN        = 60,
  parameter int GAP_RANGE_LOG2 = 7,
  parameter int MAX_Y          = 426,
  parameter int SCREEN_W       = 640,
  parameter int SPACING        = 240,
  parameter int SPEED          = 2,
  parameter int BIRD_X         = 200
) (
  input  logic                 system_clk,
  input  logic                 reset,
  pipe_field_scroller_if.slave bus
);
  localparam int RANGE = 1 << GAP_RANGE_LOG2;
  localparam int CW    = GAP_RANGE_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic        running_q;
  logic [10:0] pos_q [NUM_PIPES];
  logic [10:0] pos_d [NUM_PIPES];
  logic [8:0]  gap_q [NUM_PIPES];
  logic [8:0]  gap_d [NUM_PIPES];
  logic        score_q, score_d;
  logic        on_q, on_d, lower_q, lower_d;
  logic [13:0] addr_q, addr_d;
  logic [11:0] px_w, py_w, col_w, top_w, d_w;
  logic        hit_u, hit_l;
`ifdef PIPE_RANDOM_GAP_EN
  logic [9:0]  lfsr_q;
`else
  logic [CW-1:0] cnt_q, cnt_d, acc;
`endif

  function automatic logic [10:0] init_pos(input int i);
    return 11'(SCREEN_W + PIPE_W + i * SPACING);
  endfunction

  function automatic logic [8:0] init_gap(input int i);
    return 9'(GAP_MIN + ((i * (RANGE / 4)) % RANGE));
  endfunction

  function automatic logic [13:0] sat_depth(input logic [11:0] d);
    if (d > 12'(IMG_H - 1)) return 14'(IMG_H - 1);
    return 14'(d);
  endfunction

  // Control / motion next state
  always_comb begin
    state_d = state_q;
    score_d = 1'b0;
`ifndef PIPE_RANDOM_GAP_EN
    cnt_d = cnt_q;
    acc   = cnt_q;
`endif
    for (int i = 0; i < NUM_PIPES; i++) begin
      pos_d[i] = pos_q[i];
      gap_d[i] = gap_q[i];
    end
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.halt) begin
          state_d = S_HALT;
        end else if (bus.game_tick) begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (pos_q[i] > 11'(BIRD_X) && (pos_q[i] - 11'(SPEED)) <= 11'(BIRD_X))
              score_d = 1'b1;
            if (pos_q[i] <= 11'(SPEED)) begin
              pos_d[i] = pos_q[i] - 11'(SPEED) + 11'(NUM_PIPES * SPACING);
`ifdef PIPE_RANDOM_GAP_EN
              gap_d[i] = 9'(GAP_MIN) + 9'(lfsr_q[CW-1:0]);
`else
              acc      = acc + CW'(37);
              gap_d[i] = 9'(GAP_MIN) + 9'(acc);
`endif
            end else begin
              pos_d[i] = pos_q[i] - 11'(SPEED);
            end
          end
`ifndef PIPE_RANDOM_GAP_EN
          cnt_d = acc;
`endif
        end
      end
      S_HALT: begin
        if (bus.start) begin
          state_d = S_IDLE;
`ifndef PIPE_RANDOM_GAP_EN
          cnt_d = '0;
`endif
          for (int i = 0; i < NUM_PIPES; i++) begin
            pos_d[i] = init_pos(i);
            gap_d[i] = init_gap(i);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel query: first pipe whose column and vertical band both match
  always_comb begin
    on_d    = 1'b0;
    lower_d = 1'b0;
    addr_d  = '0;
    px_w    = {2'b00, bus.pixel_x};
    py_w    = {2'b00, bus.pixel_y};
    col_w   = '0;
    top_w   = '0;
    d_w     = '0;
    hit_u   = 1'b0;
    hit_l   = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (!on_d && (px_w + 12'(PIPE_W)) >= {1'b0, pos_q[i]} && px_w < {1'b0, pos_q[i]}) begin
        col_w = px_w + 12'(PIPE_W) - {1'b0, pos_q[i]};
        top_w = {3'b000, gap_q[i]};
        hit_u = py_w < top_w;
        hit_l = !hit_u && py_w >= (top_w + 12'(GAP)) && py_w < 12'(MAX_Y);
        d_w   = hit_u ? (top_w - 12'd1 - py_w) : (py_w - top_w - 12'(GAP));
        if (hit_u || hit_l) begin
          on_d    = 1'b1;
          lower_d = hit_l;
          addr_d  = 14'(col_w) + 14'(PIPE_W) * (14'(IMG_H - 1) - sat_depth(d_w));
        end
      end
    end
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      score_q   <= 1'b0;
      on_q      <= 1'b0;
      lower_q   <= 1'b0;
      addr_q    <= '0;
`ifndef PIPE_RANDOM_GAP_EN
      cnt_q     <= '0;
`endif
      for (int i = 0; i < NUM_PIPES; i++) begin
        pos_q[i] <= init_pos(i);
        gap_q[i] <= init_gap(i);
      end
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN);
      score_q   <= score_d;
      on_q      <= on_d;
      lower_q   <= lower_d;
      addr_q    <= addr_d;
`ifndef PIPE_RANDOM_GAP_EN
      cnt_q     <= cnt_d;
`endif
      for (int i = 0; i < NUM_PIPES; i++) begin
        pos_q[i] <= pos_d[i];
        gap_q[i] <= gap_d[i];
      end
    end
  end

`ifdef PIPE_RANDOM_GAP_EN
  // Fibonacci LFSR, taps 10 and 7; seeded nonzero so it never locks up
  always_ff @(posedge system_clk) begin
    if (reset) lfsr_q <= 10'h001;
    else       lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end
`endif

  assign bus.pipe_on     = on_q;
  assign bus.pipe_lower  = lower_q;
  assign bus.rom_addr    = addr_q;
  assign bus.score_pulse = score_q;
  assign bus.running     = running_q;
endmodule

// File: tb/tb_pipe_field_scroller.sv
// Bench for pipe_field_scroller: fixed vector table, directed scroll/score/respawn/halt
// sequences, then random traffic checked against a behavioural model of the pipe field.
module tb_pipe_field_scroller;
  localparam int NP = 3, PW = 41, IH = 253, GAPP = 70, GMIN = 60, RL = 7, MAXY = 426;
  localparam int SW = 640, SP = 240, SPD = 2, BX = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_field_scroller_if bus ();
  pipe_field_scroller dut (.system_clk(clk), .reset(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_pos [NP];
  int m_gap [NP];
  int m_cnt;
  int m_state;  // 0 idle, 1 run, 2 halted
  int m_on, m_low, m_addr, m_sc, m_run;

  typedef struct {
    bit r, t, s, h;
    int px, py;
    bit on, low;
    int addr;
    bit sc, run;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < NP; i++) begin
      m_pos[i] = SW + PW + i * SP;
      m_gap[i] = GMIN + (i * ((1 << RL) / 4)) % (1 << RL);
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input bit r, t, s, h, input int px, input int py);
    int left, d;
    bit found;
    if (r) begin
      model_init();
      m_state = 0; m_on = 0; m_low = 0; m_addr = 0; m_sc = 0; m_run = 0;
      return;
    end
    m_on = 0; m_low = 0; m_addr = 0; found = 0; d = 0;
    for (int i = 0; i < NP; i++) begin
      left = m_pos[i] - PW;
      if (!found && px >= left && px < m_pos[i]) begin
        if (py < m_gap[i]) begin
          found = 1; m_low = 0; d = m_gap[i] - 1 - py;
        end else if (py >= m_gap[i] + GAPP && py < MAXY) begin
          found = 1; m_low = 1; d = py - m_gap[i] - GAPP;
        end
        if (found) begin
          if (d > IH - 1) d = IH - 1;
          m_on = 1;
          m_addr = (px - left) + PW * (IH - 1 - d);
        end
      end
    end
    m_sc = 0;
    case (m_state)
      0: if (s) m_state = 1;
      1: begin
        if (h) m_state = 2;
        else if (t) begin
          for (int i = 0; i < NP; i++) begin
            if (m_pos[i] > BX && m_pos[i] - SPD <= BX) m_sc = 1;
            if (m_pos[i] <= SPD) begin
              m_pos[i] = m_pos[i] - SPD + NP * SP;
              m_cnt = (m_cnt + 37) % (1 << RL);
              m_gap[i] = GMIN + m_cnt;
            end else m_pos[i] = m_pos[i] - SPD;
          end
        end
      end
      default: if (s) begin m_state = 0; model_init(); end
    endcase
    m_run = (m_state == 1) ? 1 : 0;
  endtask

  task automatic step(input bit r, t, s, h, input int px, input int py);
    rst = r;
    bus.game_tick = t;
    bus.start = s;
    bus.halt = h;
    bus.pixel_x = 10'(px);
    bus.pixel_y = 10'(py);
    model_step(r, t, s, h, px, py);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_on"},    32'(bus.pipe_on),     32'(m_on));
    chk({tag, "_lower"}, 32'(bus.pipe_lower),  32'(m_low));
    chk({tag, "_addr"},  32'(bus.rom_addr),    32'(m_addr));
    chk({tag, "_score"}, 32'(bus.score_pulse), 32'(m_sc));
    chk({tag, "_run"},   32'(bus.running),     32'(m_run));
  endtask

  function automatic int clip(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  initial begin
    int sc_cnt, k, px, py;
    bus.game_tick = 1'b0; bus.start = 1'b0; bus.halt = 1'b0;
    bus.pixel_x = '0; bus.pixel_y = '0;

    //        r t s h  px   py  on low addr  sc run
    tv[0]  = '{1,0,0,0, 100, 100, 0, 0,     0, 0, 0};
    tv[1]  = '{0,0,0,0, 100, 100, 0, 0,     0, 0, 0};
    tv[2]  = '{0,0,0,0, 645,  10, 1, 0,  8328, 0, 0};
    tv[3]  = '{0,0,0,0, 645, 130, 1, 1, 10337, 0, 0};
    tv[4]  = '{0,0,0,0, 645, 129, 0, 0,     0, 0, 0};
    tv[5]  = '{0,0,0,0, 645, 425, 1, 1,     5, 0, 0};
    tv[6]  = '{0,0,0,0, 645, 426, 0, 0,     0, 0, 0};
    tv[7]  = '{0,0,0,0, 639,  10, 0, 0,     0, 0, 0};
    tv[8]  = '{0,0,0,0, 680,  59, 1, 0, 10372, 0, 0};
    tv[9]  = '{0,0,0,0, 900,  50, 1, 0,  8671, 0, 0};
    tv[10] = '{0,0,1,0, 681,  10, 0, 0,     0, 0, 1};
    tv[11] = '{0,0,0,0, 660,   0, 1, 0,  7933, 0, 1};

    for (int i = 0; i < 12; i++) begin
      step(tv[i].r, tv[i].t, tv[i].s, tv[i].h, tv[i].px, tv[i].py);
      chk($sformatf("vec%0d_on", i),    32'(bus.pipe_on),     32'(tv[i].on));
      chk($sformatf("vec%0d_lower", i), 32'(bus.pipe_lower),  32'(tv[i].low));
      chk($sformatf("vec%0d_addr", i),  32'(bus.rom_addr),    32'(tv[i].addr));
      chk($sformatf("vec%0d_score", i), 32'(bus.score_pulse), 32'(tv[i].sc));
      chk($sformatf("vec%0d_run", i),   32'(bus.running),     32'(tv[i].run));
    end

    // 100 ticks: pipe 0 moves 681 -> 481
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 0, 0, $urandom_range(0, 1023), $urandom_range(0, 511));
      check_model("scroll");
    end
    step(0, 0, 0, 0, 450, 10);
    chk("after100_on", 32'(bus.pipe_on), 32'd1);
    chk("after100_lower", 32'(bus.pipe_lower), 32'd0);
    chk("after100_addr", 32'(bus.rom_addr), 32'd8333);

    // Approach BIRD_X without crossing, then cross once
    sc_cnt = 0;
    for (int i = 0; i < 140; i++) begin
      step(0, 1, 0, 0, 300, 300);
      sc_cnt += int'(bus.score_pulse);
    end
    chk("no_early_score", 32'(sc_cnt), 32'd0);
    step(0, 1, 0, 0, 300, 300);
    chk("cross_score", 32'(bus.score_pulse), 32'd1);
    step(0, 1, 0, 0, 300, 300);
    chk("score_one_cycle", 32'(bus.score_pulse), 32'd0);

    // Pipe 0: 197 -> 1 over 98 ticks, then respawn at 719 with gap GAP_MIN+37
    for (int i = 0; i < 98; i++) begin
      step(0, 1, 0, 0, 500, 20);
      check_model("toedge");
    end
    step(0, 1, 0, 0, 0, 10);
    check_model("respawn_tick");
    step(0, 0, 0, 0, 0, 10);
    chk("respawn_px0_on", 32'(bus.pipe_on), 32'd0);
    step(0, 0, 0, 0, 690, 10);
    chk("respawn_addr", 32'(bus.rom_addr), 32'd6818);
    step(0, 0, 0, 0, 690, 167);
    chk("respawn_lower", 32'(bus.pipe_lower), 32'd1);

    // halt with a simultaneous tick: no move, running drops
    step(0, 1, 0, 1, 690, 10);
    chk("halt_run", 32'(bus.running), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 690, 10);
    chk("halt_frozen_addr", 32'(bus.rom_addr), 32'd6818);
    chk("halt_frozen_run", 32'(bus.running), 32'd0);
    step(0, 0, 1, 0, 645, 10);
    chk("halt_to_idle_run", 32'(bus.running), 32'd0);
    step(0, 0, 0, 0, 645, 10);
    chk("idle_init_addr", 32'(bus.rom_addr), 32'd8328);
    step(0, 0, 1, 0, 645, 10);
    chk("restart_run", 32'(bus.running), 32'd1);
    check_model("restart");

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, NP - 1);
      if ($urandom_range(0, 1) == 0) px = clip(m_pos[k] - PW + $urandom_range(0, 44) - 2, 1023);
      else px = $urandom_range(0, 1023);
      case ($urandom_range(0, 3))
        0: py = clip(m_gap[k] + $urandom_range(0, 4) - 2, 1023);
        1: py = clip(m_gap[k] + GAPP + $urandom_range(0, 4) - 2, 1023);
        2: py = $urandom_range(MAXY - 2, MAXY + 1);
        default: py = $urandom_range(0, 511);
      endcase
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), px, py);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_field_scroller.md
# pipe_field_scroller

Parametrised pipe-field generator for the Flappy Bird game: owns NUM_PIPES upper/lower pipe pairs, scrolls them left on each game tick, respawns them off the right edge with a new gap height, and answers the VGA pixel query with a registered hit flag and image-ROM address. It supersedes the fixed per-pipe modules: a single instance drives every pipe ROM and the score counter. It sits between the game-tick generator and the pixel mux, beside the bird module.

## Interface
- NUM_PIPES, 3, number of pipe pairs (1..4)
- PIPE_W, 41, pipe width in pixels, also the ROM line length
- IMG_H, 253, rows in the pipe image ROM
- GAP, 70, vertical opening in pixels
- GAP_MIN, 60, smallest gap top row
- GAP_RANGE_LOG2, 7, gap top spans GAP_MIN .. GAP_MIN+2^GAP_RANGE_LOG2-1
- MAX_Y, 426, ground row; lower pipe ends at MAX_Y-1
- SCREEN_W, 640, visible width
- SPACING, 240, horizontal pitch between pipes; NUM_PIPES*SPACING >= SCREEN_W+PIPE_W
- SPEED, 2, pixels moved per game tick (1..PIPE_W)
- BIRD_X, 200, column used for score detection
- system_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- game_tick  in  1  one-cycle move strobe (replaces the separate game_clk)
- start  in  1  level/pulse, begin or restart
- halt  in  1  freeze motion (collision)
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- pipe_on  out  1  pixel lies on any pipe (registered)
- pipe_lower  out  1  hit is on a lower pipe (registered)
- rom_addr  out  14  address into the pipe image ROM (registered)
- score_pulse  out  1  one cycle per pipe passing BIRD_X
- running  out  1  state is RUN

## Operation
- Per pipe i: 11-bit pos[i] = right-edge column + 0; pipe covers columns [pos-PIPE_W, pos); gap_t[i] 9-bit.
- Init (reset or IDLE entry): pos[i] = SCREEN_W+PIPE_W+i*SPACING; gap_t[i] = GAP_MIN + i*(2^GAP_RANGE_LOG2/4) mod range.
- FSM: IDLE -> RUN on start; RUN -> HALT on halt; HALT -> IDLE on start. halt has priority over start in RUN. Reset -> IDLE.
- RUN and game_tick: if pos[i] <= SPEED, pos[i] <= pos[i]-SPEED+NUM_PIPES*SPACING and gap_t[i] reloads; else pos[i] <= pos[i]-SPEED. All pipes update in the same cycle.
- Score: in RUN, game_tick, pos[i] > BIRD_X and pos[i]-SPEED <= BIRD_X for any i -> score_pulse next cycle (one pulse even if two pipes cross together).
- Pixel query: column hit when pos-PIPE_W <= pixel_x < pos (compare in 11 bits, no wrap). Upper hit: pixel_y < gap_t. Lower hit: gap_t+GAP <= pixel_y < MAX_Y. Lowest index wins on overlap.
- col = pixel_x-(pos-PIPE_W); d = upper ? gap_t-1-pixel_y : pixel_y-(gap_t+GAP); d saturates at IMG_H-1; rom_addr = col + PIPE_W*(IMG_H-1-d) (14-bit, never exceeds PIPE_W*IMG_H-1).
- No hit: pipe_on=0, pipe_lower=0, rom_addr=0.
- IDLE and HALT: pixel query still active (frozen pipes drawn); no moves, no score.

## Timing
- Pixel outputs: 1 cycle after pixel_x/pixel_y; ROM adds its own cycle, pixel mux aligns.
- Movement/respawn: registered on the cycle game_tick is sampled high; visible to pixel query the next cycle.
- score_pulse: exactly 1 cycle, cycle after the crossing tick.
- Reset values: pipe_on 0, pipe_lower 0, rom_addr 0, score_pulse 0, running 0, positions/gaps at init, LFSR 10'h1.
- Reset mid-frame: takes effect next edge, overrides tick/start/halt.
- halt and game_tick same cycle in RUN: no move, enter HALT.

## Configuration
- PIPE_RANDOM_GAP_EN defined: 10-bit Fibonacci LFSR (taps 10,7), advancing every cycle, never zero; reload gap_t = GAP_MIN + lfsr[GAP_RANGE_LOG2-1:0].
- Undefined: no LFSR; respawn counter incremented by 37 per reload, gap_t = GAP_MIN + counter[GAP_RANGE_LOG2-1:0]; fully deterministic sequence.

## Test plan
- Reset, defaults -> pos = 681, 921, 1161; running 0; pixel (100,100) pipe_on 0.
- start, 100 ticks, SPEED 2 -> pipe 0 pos 481; pixel (450,10) one cycle later: pipe_on 1, pipe_lower 0, rom_addr = 10+41*(252-(gap_t0-11)) clamped.
- Pipe 0 at pos 2, tick -> pos 720, gap_t reloaded (macro off: GAP_MIN+37), no negative column hit at pixel_x 0.
- pos 201 -> 199 across BIRD_X 200 -> single score_pulse; repeat tick with no crossing -> 0.
- halt with tick same cycle -> pos unchanged, running 0; further ticks ignored; start -> IDLE init positions; start -> running 1.
- Pixel at row gap_t+GAP-1 -> pipe_on 0; row gap_t+GAP -> pipe_lower 1, rom_addr = col+41*252; row MAX_Y -> pipe_on 0.
